// File: rtl/fir_tap_loader.sv
// FIR tap loader: holds a shadow copy of the FIR taps and, on request,
// restarts the FIR tap programming and streams every tap in index order
// over a valid/ready interface, then waits for the FIR to acknowledge.
module fir_tap_loader #(
    parameter int unsigned G_NUM_TAPS_LOG2 = 4,
    parameter int unsigned G_TAP_WIDTH     = 16,
    parameter int unsigned G_DONE_TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_wr_en,
    input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       fir_enable,
    output logic [G_TAP_WIDTH-1:0]     tap_dout,
    output logic                       tap_dout_valid,
    input  logic                       tap_dout_ready,
    input  logic                       tap_done
);

    localparam int unsigned LP_N     = 1 << G_NUM_TAPS_LOG2;
    localparam int unsigned LP_IDX_W = G_NUM_TAPS_LOG2 + 1;
    localparam int unsigned LP_CNT_W = $clog2(G_DONE_TIMEOUT) + 1;

    typedef enum logic [2:0] {
        SM_IDLE,
        SM_FIR_RESET,
        SM_PREFETCH,
        SM_STREAM,
        SM_WAIT_DONE
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic                    r_fir_enable;
    logic [LP_CNT_W-1:0]     r_cnt;
    logic [LP_IDX_W-1:0]     r_rd_idx;
    logic [LP_IDX_W-1:0]     r_xfer_cnt;
    logic                    r_done_seen;

    // Shadow memory and its registered read port
    logic [G_TAP_WIDTH-1:0]  r_mem [LP_N];
    logic [G_TAP_WIDTH-1:0]  r_rd_data;
    logic                    r_rd_vld;

    // Output register plus one-entry skid buffer
    logic [G_TAP_WIDTH-1:0]  r_dout;
    logic                    r_valid;
    logic [G_TAP_WIDTH-1:0]  r_skid;
    logic                    r_skid_vld;

    logic                    w_xfer;
    logic                    w_issue;
    logic [1:0]              w_occ;

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign fir_enable     = r_fir_enable;
    assign tap_dout       = r_dout;
    assign tap_dout_valid = r_valid;

    // Read-ahead control: issue a read whenever the data it returns is
    // guaranteed a slot in the output register or skid buffer.
    always_comb begin
        w_xfer  = r_valid & tap_dout_ready;
        w_occ   = {1'b0, r_valid} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld}
                - {1'b0, w_xfer};
        w_issue = 1'b0;
        if (r_state == SM_FIR_RESET && r_cnt == LP_CNT_W'(1)) begin
            w_issue = 1'b1;
        end else if ((r_state == SM_PREFETCH || r_state == SM_STREAM) &&
                     r_rd_idx != LP_IDX_W'(LP_N) && w_occ < 2'd2) begin
            w_issue = 1'b1;
        end
    end

    // Shadow memory: writes only while idle; contents survive reset
    always_ff @(posedge clk) begin
        if (cfg_wr_en && !r_busy) begin
            r_mem[cfg_wr_addr] <= cfg_wr_data;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_idx[G_NUM_TAPS_LOG2-1:0]];
        end
    end

    // Load sequencer, read pipeline and output/skid datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SM_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_fir_enable <= 1'b0;
            r_cnt        <= '0;
            r_rd_idx     <= '0;
            r_xfer_cnt   <= '0;
            r_done_seen  <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
            r_skid       <= '0;
            r_skid_vld   <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_idx <= r_rd_idx + LP_IDX_W'(1);
            end

            // Skid entry is older than the read arriving this cycle, so it
            // drains first; arrivals park in the skid while output stalls.
            if (!r_valid || w_xfer) begin
                if (r_skid_vld) begin
                    r_dout     <= r_skid;
                    r_valid    <= 1'b1;
                    r_skid_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_skid <= r_rd_data;
                    end
                end else if (r_rd_vld) begin
                    r_dout  <= r_rd_data;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end else if (r_rd_vld) begin
                r_skid     <= r_rd_data;
                r_skid_vld <= 1'b1;
            end

            case (r_state)
                SM_IDLE: begin
                    if (start) begin
                        r_state      <= SM_FIR_RESET;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_fir_enable <= 1'b0;
                        r_cnt        <= '0;
                        r_rd_idx     <= '0;
                        r_xfer_cnt   <= '0;
                        r_done_seen  <= 1'b0;
                    end
                end
                SM_FIR_RESET: begin
                    if (r_cnt == LP_CNT_W'(1)) begin
                        r_fir_enable <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= SM_PREFETCH;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_W'(1);
                    end
                end
                SM_PREFETCH: begin
                    r_state <= SM_STREAM;
                end
                SM_STREAM: begin
                    // An early acknowledge is remembered for the wait state
                    if (tap_done) begin
                        r_done_seen <= 1'b1;
                    end
                    if (w_xfer) begin
                        r_xfer_cnt <= r_xfer_cnt + LP_IDX_W'(1);
                        if (r_xfer_cnt == LP_IDX_W'(LP_N - 1)) begin
                            r_cnt   <= '0;
                            r_state <= SM_WAIT_DONE;
                        end
                    end
                end
                SM_WAIT_DONE: begin
                    if (tap_done || r_done_seen) begin
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_fir_enable <= 1'b1;
                        r_state      <= SM_IDLE;
                    end else if (r_cnt == LP_CNT_W'(G_DONE_TIMEOUT - 1)) begin
                        r_error      <= 1'b1;
                        r_busy       <= 1'b0;
                        r_fir_enable <= 1'b0;
                        r_state      <= SM_IDLE;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= SM_IDLE;
                end
            endcase
        end
    end

endmodule
